// File: rtl/fft_fixed_pkg.sv
// Shared fixed-point definitions for the FFT datapath: default format,
// saturation limits and the divider state encoding.
package fft_fixed_pkg;

    localparam int unsigned N = 16;
    localparam int unsigned Q = 8;

    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/fixed_sat.sv
// Applies a result sign to an unsigned magnitude and saturates it into an
// N-bit two's complement word.
module fixed_sat #(
    parameter int unsigned N  = 16,
    parameter int unsigned MW = 24
) (
    input  logic [MW-1:0] mag,
    input  logic          neg,
    output logic [N-1:0]  value_c,
    output logic          ovf_c
);

    localparam logic [N-1:0]  MAX_V = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  MIN_V = {1'b1, {(N-1){1'b0}}};
    localparam logic [MW-1:0] LIM   = MW'(1) << (N-1);

    // A negative magnitude of exactly 2^(N-1) is representable; positive is not.
    always_comb begin
        value_c = mag[N-1:0];
        ovf_c   = 1'b0;
        if (!neg) begin
            if (mag >= LIM) begin
                value_c = MAX_V;
                ovf_c   = 1'b1;
            end
        end else begin
            if (mag > LIM) begin
                value_c = MIN_V;
                ovf_c   = 1'b1;
            end else begin
                value_c = N'(0) - mag[N-1:0];
            end
        end
    end

endmodule

// File: rtl/fixed_divider.sv
// Signed fixed-point divider: restoring division on magnitudes, one quotient
// bit per clock, followed by sign application and saturation.
module fixed_divider #(
    parameter int unsigned N = fft_fixed_pkg::N,
    parameter int unsigned Q = fft_fixed_pkg::Q
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_A,
    input  logic [N-1:0] i_B,
    output logic [N-1:0] o_quot,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_div_zero,
    output logic         o_ovf
);

    import fft_fixed_pkg::*;

    localparam int unsigned DW = N + Q;
    localparam int unsigned RW = N + 1;
    localparam int unsigned CW = $clog2(N + Q + 1);

    localparam logic [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

    // Most negative input maps to 2^(N-1), which still fits N unsigned bits.
    function automatic logic [N-1:0] abs_val(input logic [N-1:0] x);
        return x[N-1] ? N'(~x + N'(1)) : x;
    endfunction

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [N-1:0]  mag_b_q, mag_b_d;
    logic          neg_q, neg_d;
    logic          a_neg_q, a_neg_d;
    logic          dz_q, dz_d;
    logic [N-1:0]  quot_q, quot_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          div_zero_q, div_zero_d;
    logic          ovf_q, ovf_d;

    logic [RW:0]   rem_sh;
    logic [RW-1:0] diff;
    logic          ge;
    logic [N-1:0]  sat_val;
    logic          sat_ovf;

    // Restoring step: the dividend register shifts out its MSB and takes the quotient bit in.
    assign rem_sh = {rem_q, dvd_q[DW-1]};
    assign ge     = rem_sh >= {2'b00, mag_b_q};
    assign diff   = rem_sh[RW-1:0] - {1'b0, mag_b_q};

    fixed_sat #(
        .N  (N),
        .MW (DW)
    ) u_sat (
        .mag     (dvd_q),
        .neg     (neg_q),
        .value_c (sat_val),
        .ovf_c   (sat_ovf)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        mag_b_d    = mag_b_q;
        neg_d      = neg_q;
        a_neg_d    = a_neg_q;
        dz_d       = dz_q;
        quot_d     = quot_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    mag_b_d = abs_val(i_B);
                    dvd_d   = {abs_val(i_A), {Q{1'b0}}};
                    rem_d   = '0;
                    neg_d   = i_A[N-1] ^ i_B[N-1];
                    a_neg_d = i_A[N-1];
                    dz_d    = (i_B == '0);
                    cnt_d   = CW'(DW - 1);
                    busy_d  = 1'b1;
                    state_d = (i_B == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d = ge ? diff : rem_sh[RW-1:0];
                dvd_d = {dvd_q[DW-2:0], ge};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (dz_q) begin
                    quot_d     = a_neg_q ? MIN_V : MAX_V;
                    div_zero_d = 1'b1;
                    ovf_d      = 1'b0;
                end else begin
                    quot_d     = sat_val;
                    div_zero_d = 1'b0;
                    ovf_d      = sat_ovf;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            mag_b_q    <= '0;
            neg_q      <= 1'b0;
            a_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            quot_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            mag_b_q    <= mag_b_d;
            neg_q      <= neg_d;
            a_neg_q    <= a_neg_d;
            dz_q       <= dz_d;
            quot_q     <= quot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_quot     = quot_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_div_zero = div_zero_q;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_fixed_divider.sv
// Directed bench for fixed_divider (Q8.8): latency, rounding, saturation,
// divide-by-zero, reset abort, busy-ignore and back-to-back starts.
module tb_fixed_divider;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [15:0] i_A;
    logic [15:0] i_B;
    logic [15:0] o_quot;
    logic        o_busy;
    logic        o_done;
    logic        o_div_zero;
    logic        o_ovf;

    int checks = 0;
    int fails  = 0;

    fixed_divider #(.N(16), .Q(8)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_A        (i_A),
        .i_B        (i_B),
        .o_quot     (o_quot),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_div_zero (o_div_zero),
        .o_ovf      (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    // Issue one request and count edges from acceptance to o_done (-1 on timeout).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic dz, output logic ov,
                          output logic bz, output int edges);
        @(negedge i_clk);
        i_A = a; i_B = b; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        bz = o_busy;
        edges = -1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge i_clk); #1;
            if (o_done) begin
                edges = e;
                break;
            end
        end
        q = o_quot; dz = o_div_zero; ov = o_ovf;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b0; i_A = '0; i_B = '0;
        @(posedge i_clk); #1;
        checks++; if ({o_quot, o_busy, o_done, o_div_zero, o_ovf} !== 20'h0) begin fails++; $display("FAIL reset_outputs: got %h want 00000", {o_quot, o_busy, o_done, o_div_zero, o_ovf}); end
        @(negedge i_clk); i_rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] q; logic dz, ov, bz; int edges;
        run_op(16'h0300, 16'h0200, q, dz, ov, bz, edges);
        checks++; if (bz !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b want 1", bz); end
        checks++; if (edges != 25) begin fails++; $display("FAIL basic_latency: got %0d want 25", edges); end
        checks++; if (q !== 16'h0180) begin fails++; $display("FAIL basic_quot: got %h want 0180", q); end
        checks++; if ({dz, ov} !== 2'b00) begin fails++; $display("FAIL basic_flags: got %b want 00", {dz, ov}); end
        @(posedge i_clk); #1;
        checks++; if ({o_done, o_busy} !== 2'b00) begin fails++; $display("FAIL basic_done_pulse: got %b want 00", {o_done, o_busy}); end
        checks++; if (o_quot !== 16'h0180) begin fails++; $display("FAIL basic_hold: got %h want 0180", o_quot); end
    endtask

    task automatic test_truncation();
        logic [15:0] q; logic dz, ov, bz; int edges;
        run_op(16'hFD00, 16'h0200, q, dz, ov, bz, edges);
        checks++; if (q !== 16'hFE80) begin fails++; $display("FAIL trunc_neg_a: got %h want fe80", q); end
        run_op(16'h0100, 16'hFD00, q, dz, ov, bz, edges);
        checks++; if (q !== 16'hFFAB) begin fails++; $display("FAIL trunc_third: got %h want ffab", q); end
        checks++; if (ov !== 1'b0) begin fails++; $display("FAIL trunc_ovf: got %b want 0", ov); end
    endtask

    task automatic test_saturation();
        logic [15:0] q; logic dz, ov, bz; int edges;
        run_op(16'h7F00, 16'h0080, q, dz, ov, bz, edges);
        checks++; if ({q, ov} !== {16'h7FFF, 1'b1}) begin fails++; $display("FAIL sat_pos: got %h/%b want 7fff/1", q, ov); end
        run_op(16'h8000, 16'h0100, q, dz, ov, bz, edges);
        checks++; if ({q, ov} !== {16'h8000, 1'b0}) begin fails++; $display("FAIL sat_min_exact: got %h/%b want 8000/0", q, ov); end
        run_op(16'h8000, 16'hFF00, q, dz, ov, bz, edges);
        checks++; if ({q, ov} !== {16'h7FFF, 1'b1}) begin fails++; $display("FAIL sat_min_neg1: got %h/%b want 7fff/1", q, ov); end
        run_op(16'h0000, 16'hFF00, q, dz, ov, bz, edges);
        checks++; if ({q, ov} !== {16'h0000, 1'b0}) begin fails++; $display("FAIL zero_neg: got %h/%b want 0000/0", q, ov); end
    endtask

    task automatic test_div_zero();
        logic [15:0] q; logic dz, ov, bz; int edges;
        run_op(16'hFF00, 16'h0000, q, dz, ov, bz, edges);
        checks++; if (edges != 1) begin fails++; $display("FAIL dz_latency: got %0d want 1", edges); end
        checks++; if ({q, dz, ov} !== {16'h8000, 1'b1, 1'b0}) begin fails++; $display("FAIL dz_neg: got %h/%b/%b want 8000/1/0", q, dz, ov); end
        run_op(16'h0100, 16'h0000, q, dz, ov, bz, edges);
        checks++; if ({q, dz, ov} !== {16'h7FFF, 1'b1, 1'b0}) begin fails++; $display("FAIL dz_pos: got %h/%b/%b want 7fff/1/0", q, dz, ov); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] q; logic dz, ov, bz; int edges; int seen;
        @(negedge i_clk);
        i_A = 16'h0300; i_B = 16'h0200; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (10) @(posedge i_clk);
        #1 i_rst = 1'b1;
        #1;
        checks++; if ({o_quot, o_busy, o_done, o_div_zero, o_ovf} !== 20'h0) begin fails++; $display("FAIL rst_mid_outputs: got %h want 00000", {o_quot, o_busy, o_done, o_div_zero, o_ovf}); end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        seen = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge i_clk); #1;
            if (o_done) seen++;
        end
        checks++; if (seen != 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", seen); end
        run_op(16'h0100, 16'h0200, q, dz, ov, bz, edges);
        checks++; if (edges != 25 || q !== 16'h0080) begin fails++; $display("FAIL rst_mid_fresh: got %0d/%h want 25/0080", edges, q); end
    endtask

    task automatic test_busy_ignore();
        int edges; int seen;
        @(negedge i_clk);
        i_A = 16'hFD00; i_B = 16'h0200; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        edges = -1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge i_clk); #1;
            if (e == 5) begin i_A = 16'h0100; i_B = 16'h0000; i_start = 1'b1; end
            if (e == 7) i_start = 1'b0;
            if (o_done) begin
                edges = e;
                break;
            end
        end
        checks++; if (edges != 25) begin fails++; $display("FAIL busy_latency: got %0d want 25", edges); end
        checks++; if ({o_quot, o_div_zero} !== {16'hFE80, 1'b0}) begin fails++; $display("FAIL busy_result: got %h/%b want fe80/0", o_quot, o_div_zero); end
        seen = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge i_clk); #1;
            if (o_done) seen++;
        end
        checks++; if (seen != 0) begin fails++; $display("FAIL busy_extra_done: got %0d want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q; logic dz, ov, bz; int edges;
        run_op(16'h0300, 16'h0200, q, dz, ov, bz, edges);
        checks++; if (q !== 16'h0180) begin fails++; $display("FAIL b2b_first: got %h want 0180", q); end
        i_A = 16'hFD00; i_B = 16'h0200; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        edges = -1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge i_clk); #1;
            if (o_done) begin
                edges = e;
                break;
            end
        end
        checks++; if (edges != 25) begin fails++; $display("FAIL b2b_latency: got %0d want 25", edges); end
        checks++; if (o_quot !== 16'hFE80) begin fails++; $display("FAIL b2b_second: got %h want fe80", o_quot); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_saturation();
        test_div_zero();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
